// File: rtl/alu_dp_sequencer.sv
// DP control sequencer: decodes the DP command and sequences iterative shift-add MUL.
// Optional MUL early termination on mul_rem_zero is enabled by defining MUL_EARLY_TERM_EN.
module alu_dp_sequencer #(
    parameter int WIDTH     = 32,
    parameter int MUL_STEPS = WIDTH,
    parameter int STEP_W    = ($clog2(MUL_STEPS) > 0) ? $clog2(MUL_STEPS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              ALUOp,
    input  logic [4:0]        Funct,
    input  logic              is_mul,
    input  logic              mul_rem_zero,
    output logic              step_en,
    output logic [STEP_W-1:0] step_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        ALUControl,
    output logic              ALUSrcA,
    output logic [1:0]        FlagW,
    output logic              NoWrite,
    output logic              illegal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q;
    logic               step_en_q;
    logic [STEP_W-1:0]  step_idx_q;
    logic               out_valid_q;
    logic [2:0]         ctl_q;
    logic               srca_q;
    logic [1:0]         flagw_q;
    logic               nowrite_q;
    logic               illegal_q;
    logic               mul_s_q;

    logic               accept;
    logic               accept_mul;
    logic               step_last;
    logic               step_done;

    logic [2:0]         dec_ctl_d;
    logic               dec_srca_d;
    logic [1:0]         dec_flagw_d;
    logic               dec_nowrite_d;
    logic               dec_illegal_d;

    assign in_ready   = (state_q == IDLE) | ((state_q == RESP) & out_ready);
    assign accept     = in_valid & in_ready;
    assign accept_mul = ALUOp & is_mul;
    assign step_last  = (step_idx_q == STEP_W'(MUL_STEPS - 1));

`ifdef MUL_EARLY_TERM_EN
    assign step_done = step_last | mul_rem_zero;
`else
    logic unused_rem_zero;
    assign unused_rem_zero = mul_rem_zero;
    assign step_done       = step_last;
`endif

    // Decode for the non-MUL path; ALUOp=0 leaves the address-add defaults in place.
    always_comb begin
        dec_ctl_d     = 3'b000;
        dec_srca_d    = 1'b1;
        dec_flagw_d   = 2'b00;
        dec_nowrite_d = 1'b0;
        dec_illegal_d = 1'b0;
        if (ALUOp) begin
            case (Funct[4:1])
                4'b0000: begin dec_ctl_d = 3'b010; dec_flagw_d = Funct[0] ? 2'b10 : 2'b00; end
                4'b0001: begin dec_ctl_d = 3'b100; dec_flagw_d = Funct[0] ? 2'b10 : 2'b00; end
                4'b0010: begin dec_ctl_d = 3'b001; dec_flagw_d = Funct[0] ? 2'b11 : 2'b00; end
                4'b0011: begin dec_ctl_d = 3'b101; dec_flagw_d = Funct[0] ? 2'b11 : 2'b00; end
                4'b0100: begin dec_ctl_d = 3'b000; dec_flagw_d = Funct[0] ? 2'b11 : 2'b00; end
                4'b0101, 4'b0110, 4'b0111: begin
                    dec_illegal_d = 1'b1;
                    dec_nowrite_d = 1'b1;
                end
                4'b1000: begin dec_ctl_d = 3'b010; dec_flagw_d = 2'b10; dec_nowrite_d = 1'b1; end
                4'b1001: begin dec_ctl_d = 3'b100; dec_flagw_d = 2'b10; dec_nowrite_d = 1'b1; end
                4'b1010: begin dec_ctl_d = 3'b001; dec_flagw_d = 2'b11; dec_nowrite_d = 1'b1; end
                4'b1011: begin dec_ctl_d = 3'b000; dec_flagw_d = 2'b11; dec_nowrite_d = 1'b1; end
                4'b1100: begin dec_ctl_d = 3'b011; dec_flagw_d = Funct[0] ? 2'b10 : 2'b00; end
                4'b1101: begin dec_srca_d = 1'b0;  dec_flagw_d = Funct[0] ? 2'b10 : 2'b00; end
                4'b1110: begin dec_ctl_d = 3'b110; dec_flagw_d = Funct[0] ? 2'b10 : 2'b00; end
                default: begin dec_ctl_d = 3'b111; dec_flagw_d = Funct[0] ? 2'b10 : 2'b00; end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            step_en_q   <= 1'b0;
            step_idx_q  <= '0;
            out_valid_q <= 1'b0;
            ctl_q       <= 3'b000;
            srca_q      <= 1'b1;
            flagw_q     <= 2'b00;
            nowrite_q   <= 1'b0;
            illegal_q   <= 1'b0;
            mul_s_q     <= 1'b0;
        end else begin
            case (state_q)
                STEP: begin
                    if (step_done) begin
                        state_q     <= RESP;
                        step_en_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        nowrite_q   <= 1'b0;
                        flagw_q     <= mul_s_q ? 2'b10 : 2'b00;
                    end else begin
                        step_idx_q  <= step_idx_q + 1'b1;
                    end
                end
                default: begin
                    // IDLE and RESP share the accept path so RESP can hand off back-to-back.
                    if (accept) begin
                        step_idx_q <= '0;
                        if (accept_mul) begin
                            state_q     <= STEP;
                            step_en_q   <= 1'b1;
                            out_valid_q <= 1'b0;
                            ctl_q       <= 3'b000;
                            srca_q      <= 1'b1;
                            flagw_q     <= 2'b00;
                            nowrite_q   <= 1'b1;
                            illegal_q   <= 1'b0;
                            mul_s_q     <= Funct[0];
                        end else begin
                            state_q     <= RESP;
                            step_en_q   <= 1'b0;
                            out_valid_q <= 1'b1;
                            ctl_q       <= dec_ctl_d;
                            srca_q      <= dec_srca_d;
                            flagw_q     <= dec_flagw_d;
                            nowrite_q   <= dec_nowrite_d;
                            illegal_q   <= dec_illegal_d;
                        end
                    end else if ((state_q == RESP) && out_ready) begin
                        state_q     <= IDLE;
                        step_en_q   <= 1'b0;
                        step_idx_q  <= '0;
                        out_valid_q <= 1'b0;
                        ctl_q       <= 3'b000;
                        srca_q      <= 1'b1;
                        flagw_q     <= 2'b00;
                        nowrite_q   <= 1'b0;
                        illegal_q   <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign step_en    = step_en_q;
    assign step_idx   = step_idx_q;
    assign out_valid  = out_valid_q;
    assign ALUControl = ctl_q;
    assign ALUSrcA    = srca_q;
    assign FlagW      = flagw_q;
    assign NoWrite    = nowrite_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_alu_dp_sequencer.sv
// Self-checking bench for alu_dp_sequencer: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_alu_dp_sequencer;

    localparam int WIDTH     = 32;
    localparam int MUL_STEPS = WIDTH;
    localparam int STEP_W    = ($clog2(MUL_STEPS) > 0) ? $clog2(MUL_STEPS) : 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic              ALUOp;
    logic [4:0]        Funct;
    logic              is_mul;
    logic              mul_rem_zero;
    logic              step_en;
    logic [STEP_W-1:0] step_idx;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        ALUControl;
    logic              ALUSrcA;
    logic [1:0]        FlagW;
    logic              NoWrite;
    logic              illegal;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase 0 = nothing pending, 1 = multiplying, 2 = result waiting.
    int         m_phase = 0;
    int         m_step  = 0;
    logic       m_s     = 1'b0;
    logic [2:0] m_ctl   = 3'b000;
    logic       m_srca  = 1'b1;
    logic [1:0] m_fw    = 2'b00;
    logic       m_nw    = 1'b0;
    logic       m_ill   = 1'b0;

    logic [2:0] ctl_tab [16] = '{3'd2, 3'd4, 3'd1, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0,
                                 3'd2, 3'd4, 3'd1, 3'd0, 3'd3, 3'd0, 3'd6, 3'd7};

    always #5 clk = ~clk;

    alu_dp_sequencer #(.WIDTH(WIDTH), .MUL_STEPS(MUL_STEPS)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ALUOp        (ALUOp),
        .Funct        (Funct),
        .is_mul       (is_mul),
        .mul_rem_zero (mul_rem_zero),
        .step_en      (step_en),
        .step_idx     (step_idx),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .ALUControl   (ALUControl),
        .ALUSrcA      (ALUSrcA),
        .FlagW        (FlagW),
        .NoWrite      (NoWrite),
        .illegal      (illegal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void ref_decode(input logic [4:0] f);
        int  cmd;
        bit  s, arith, cmp, bad, mov;
        cmd   = int'(f[4:1]);
        s     = f[0];
        arith = (cmd >= 2 && cmd <= 4);
        cmp   = (cmd >= 8 && cmd <= 11);
        bad   = (cmd >= 5 && cmd <= 7);
        mov   = (cmd == 13);
        m_ctl  = ctl_tab[cmd];
        m_srca = !mov;
        m_nw   = cmp || bad;
        m_ill  = bad;
        if (cmp)      m_fw = (cmd < 10) ? 2'b10 : 2'b11;
        else if (bad) m_fw = 2'b00;
        else if (!s)  m_fw = 2'b00;
        else          m_fw = arith ? 2'b11 : 2'b10;
    endfunction

    // One clock cycle: check registered outputs, drive inputs, check in_ready, advance model.
    task automatic cyc(input logic rst, input logic iv, input logic aluop, input logic [4:0] f,
                       input logic mul, input logic rz, input logic ordy);
        bit ready, done;
        @(negedge clk);
        case (m_phase)
            1: begin
                check("out_valid", 32'(out_valid), 32'd0);
                check("step_en",   32'(step_en),   32'd1);
                check("step_idx",  32'(step_idx),  32'(m_step));
                check("ALUControl",32'(ALUControl),32'd0);
                check("ALUSrcA",   32'(ALUSrcA),   32'd1);
                check("FlagW",     32'(FlagW),     32'd0);
                check("NoWrite",   32'(NoWrite),   32'd1);
                check("illegal",   32'(illegal),   32'd0);
            end
            2: begin
                check("out_valid", 32'(out_valid), 32'd1);
                check("step_en",   32'(step_en),   32'd0);
                check("ALUControl",32'(ALUControl),32'(m_ctl));
                check("ALUSrcA",   32'(ALUSrcA),   32'(m_srca));
                check("FlagW",     32'(FlagW),     32'(m_fw));
                check("NoWrite",   32'(NoWrite),   32'(m_nw));
                check("illegal",   32'(illegal),   32'(m_ill));
            end
            default: begin
                check("out_valid", 32'(out_valid), 32'd0);
                check("step_en",   32'(step_en),   32'd0);
                check("step_idx",  32'(step_idx),  32'd0);
                check("ALUControl",32'(ALUControl),32'd0);
                check("ALUSrcA",   32'(ALUSrcA),   32'd1);
                check("FlagW",     32'(FlagW),     32'd0);
                check("NoWrite",   32'(NoWrite),   32'd0);
                check("illegal",   32'(illegal),   32'd0);
            end
        endcase
        reset = rst; in_valid = iv; ALUOp = aluop; Funct = f;
        is_mul = mul; mul_rem_zero = rz; out_ready = ordy;
        #1;
        ready = (m_phase == 0) || (m_phase == 2 && ordy);
        check("in_ready", 32'(in_ready), 32'(ready));
        if (rst) begin
            m_phase = 0;
        end else if (m_phase == 1) begin
            done = (m_step == MUL_STEPS - 1);
`ifdef MUL_EARLY_TERM_EN
            if (rz) done = 1'b1;
`endif
            if (done) begin
                m_phase = 2; m_ctl = 3'b000; m_srca = 1'b1;
                m_fw = m_s ? 2'b10 : 2'b00; m_nw = 1'b0; m_ill = 1'b0;
            end else begin
                m_step++;
            end
        end else if (ready && iv) begin
            if (aluop && mul) begin
                m_phase = 1; m_step = 0; m_s = f[0];
            end else if (!aluop) begin
                m_phase = 2; m_ctl = 3'b000; m_srca = 1'b1;
                m_fw = 2'b00; m_nw = 1'b0; m_ill = 1'b0;
            end else begin
                m_phase = 2;
                ref_decode(f);
            end
        end else if (m_phase == 2 && ordy) begin
            m_phase = 0;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 5'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; ALUOp = 1'b0; Funct = '0;
        is_mul = 1'b0; mul_rem_zero = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        cyc(1'b1, 1'b1, 1'b1, 5'b01001, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 5'b0, 1'b0, 1'b0, 1'b1);

        cyc(1'b0, 1'b1, 1'b1, 5'b01001, 1'b0, 1'b0, 1'b1);   // ADDS
        cyc(1'b0, 1'b1, 1'b1, 5'b11010, 1'b0, 1'b0, 1'b1);   // MOV back-to-back
        idle_cycles(2);

        cyc(1'b0, 1'b1, 1'b1, 5'b10100, 1'b0, 1'b0, 1'b0);   // CMP, downstream stalled
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 5'b10000, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 5'b10000, 1'b0, 1'b0, 1'b1);   // TST taken on release
        idle_cycles(2);

        cyc(1'b0, 1'b1, 1'b1, 5'b00001, 1'b1, 1'b0, 1'b1);   // MULS
        for (int i = 0; i < MUL_STEPS + 3; i++)
            cyc(1'b0, 1'b0, 1'b0, 5'b0, 1'b0, (i == 5), 1'b1);

        cyc(1'b0, 1'b1, 1'b1, 5'b01010, 1'b0, 1'b0, 1'b1);   // ADC
        idle_cycles(2);

        cyc(1'b0, 1'b1, 1'b1, 5'b00000, 1'b1, 1'b0, 1'b1);   // MUL aborted at step 10
        idle_cycles(10);
        cyc(1'b1, 1'b0, 1'b0, 5'b0, 1'b0, 1'b0, 1'b1);
        idle_cycles(2);
        cyc(1'b0, 1'b1, 1'b0, 5'b10111, 1'b1, 1'b0, 1'b1);   // address add
        idle_cycles(2);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 99) < 85),
                5'($urandom),
                ($urandom_range(0, 99) < 15),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 99) < 60));
        end
        idle_cycles(MUL_STEPS + 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_dp_sequencer.md
Name: alu_dp_sequencer

Overview:
- Next-generation data-processing control for the ARM-subset core. Decodes the full 16-entry DP command field plus multiply into a 3-bit ALU control.
- Sequences multi-cycle operations: iterative shift-add MUL, with valid/ready handshakes on both sides.
- Sits between the main decoder (upstream) and the ALU/register-file/flag-write datapath (downstream).
- All control outputs are registered.

Parameters:
- WIDTH, 32: datapath width. Sets the default step count.
- MUL_STEPS, WIDTH: number of shift-add step cycles per MUL, minimum 1.
- STEP_W, $clog2(MUL_STEPS)>0 ? $clog2(MUL_STEPS) : 1: width of the step index.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream has a decoded DP instruction.
- in_ready  out  1  sequencer accepts this cycle.
- ALUOp  in  1  1 = DP instruction; 0 = address add.
- Funct  in  5  [4:1] cmd, [0] S bit.
- is_mul  in  1  instruction is MUL/MULS; valid only with ALUOp=1.
- mul_rem_zero  in  1  datapath: remaining multiplier bits are all zero.
- step_en  out  1  MUL shift-add step this cycle.
- step_idx  out  STEP_W  current step number, 0..MUL_STEPS-1.
- out_valid  out  1  final control word valid.
- out_ready  in  1  downstream consumes the control word.
- ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 RSB, 110 BIC, 111 MVN.
- ALUSrcA  out  1  0 = force operand A to zero.
- FlagW  out  2  [1] NZ write, [0] CV write.
- NoWrite  out  1  suppress register writeback.
- illegal  out  1  unsupported command, qualified by out_valid.

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on reset; polarity and synchronicity are fixed.
- Reset values: state IDLE, step_en=0, step_idx=0, out_valid=0, illegal=0, ALUControl=000, ALUSrcA=1, FlagW=00, NoWrite=0.
- Idle defaults: whenever out_valid=0 and step_en=0, control outputs hold the reset values.
- States: IDLE, STEP, RESP.
- in_ready = (state==IDLE) | (state==RESP & out_ready).
- Accept: occurs on a clock edge where in_valid & in_ready. Non-MUL goes to RESP; MUL (ALUOp & is_mul) goes to STEP with step_idx=0. Back-to-back accept from RESP is allowed.
- Non-MUL latency: accepted at edge k, out_valid high from cycle k+1.
- RESP: holds all outputs stable while out_ready=0. On out_valid & out_ready, goes to IDLE, or directly to the next instruction if one is accepted on the same edge.
- STEP: step_en=1, ALUControl=000, ALUSrcA=1, FlagW=00, NoWrite=1, out_valid=0. step_idx increments each cycle. After step MUL_STEPS-1, goes to RESP. MUL out_valid first asserts at cycle k+MUL_STEPS+1.
- MUL in RESP: ALUControl=000, ALUSrcA=1, NoWrite=0, FlagW = S ? 10 : 00.
- ALUOp=0: ADD, ALUSrcA=1, FlagW=00, NoWrite=0. Funct and is_mul are ignored.
- Decode for ALUOp=1, listed as cmd: ALUControl, with arith = CV-affecting:
  - Writeback ops: 0000 AND:010, 0001 EOR:100, 0010 SUB:001 arith, 0011 RSB:101 arith, 0100 ADD:000 arith, 1100 ORR:011, 1110 BIC:110, 1111 MVN:111.
  - 1101 MOV: 000 with ALUSrcA=0, FlagW = S ? 10 : 00.
  - Compare ops, always NoWrite=1: 1000 TST:010 FlagW=10, 1001 TEQ:100 FlagW=10, 1010 CMP:001 FlagW=11, 1011 CMN:000 FlagW=11.
  - Writeback ops: FlagW = S ? (arith ? 11 : 10) : 00. NoWrite=0.
  - 0101/0110/0111 (ADC/SBC/RSC): illegal=1, NoWrite=1, FlagW=00, ALUControl=000.
- Input ports are not sampled outside the accept edge. Funct and is_mul are latched at accept.
- Reset mid-STEP or mid-RESP: on the next cycle the state is IDLE and outputs take reset values. No out_valid is produced for the aborted instruction.
- Simultaneous reset and in_valid: reset wins; nothing is accepted.

Optional Feature:
- Macro MUL_EARLY_TERM_EN.
- Defined: in STEP, if mul_rem_zero=1 in a step cycle, go to RESP after that cycle regardless of step_idx. step_idx is not advanced further.
- Undefined: mul_rem_zero is ignored and MUL always takes exactly MUL_STEPS step cycles.

Test Plan:
- Reset held 2 cycles, then released -> in_ready=1, out_valid=0, ALUControl=000, ALUSrcA=1, FlagW=00, NoWrite=0.
- ADDS (Funct=01001), out_ready=1 -> next cycle out_valid=1, ALUControl=000, FlagW=11, NoWrite=0. MOV (11010) -> ALUSrcA=0, FlagW=00.
- CMP (10100) with out_ready=0 for 3 cycles, TST queued behind it -> CMP outputs (001/11/NoWrite=1) stable for 3 cycles, in_ready=0. On out_ready=1, TST is accepted the same edge and out_valid stays high with 010/10/NoWrite=1.
- MULS with MUL_STEPS=32 -> step_en high 32 cycles with step_idx 0..31, then out_valid with FlagW=10, NoWrite=0. MUL_EARLY_TERM_EN defined, mul_rem_zero=1 at step 5 -> RESP after 6 step cycles.
- ADC (01010) -> out_valid=1, illegal=1, NoWrite=1, FlagW=00.
- reset asserted at step 10 of a MUL -> next cycle IDLE, step_en=0, no out_valid for that MUL. A following ADD completes normally.
